// File: rtl/instrumented_adder_driver_if.sv
// Purpose: bundles the command, adder-facing and response signals of instrumented_adder_driver.
// Ports  : master = the driver (drives cmd_ready, add_*, rsp_*); slave = environment (drives active, cmd_*, add_done/sum/time, rsp_ready).
// Notes  : pure signal container, no logic.
interface instrumented_adder_driver_if;
  logic        active;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_a;
  logic [31:0] cmd_b;
  logic [31:0] cmd_ring_sel;
  logic [31:0] cmd_ext_sel;
  logic [31:0] add_a;
  logic [31:0] add_b;
  logic [31:0] add_ring_sel;
  logic [31:0] add_ext_sel;
  logic        add_start;
  logic        add_done;
  logic [31:0] add_sum;
  logic [31:0] add_time;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_sum;
  logic [31:0] rsp_time;
  logic [1:0]  rsp_status;

  modport master (
    input  active, cmd_valid, cmd_a, cmd_b, cmd_ring_sel, cmd_ext_sel,
    input  add_done, add_sum, add_time, rsp_ready,
    output cmd_ready, add_a, add_b, add_ring_sel, add_ext_sel, add_start,
    output rsp_valid, rsp_sum, rsp_time, rsp_status
  );

  modport slave (
    output active, cmd_valid, cmd_a, cmd_b, cmd_ring_sel, cmd_ext_sel,
    output add_done, add_sum, add_time, rsp_ready,
    input  cmd_ready, add_a, add_b, add_ring_sel, add_ext_sel, add_start,
    input  rsp_valid, rsp_sum, rsp_time, rsp_status
  );
endinterface

// File: rtl/instrumented_adder_driver.sv
// Purpose: sequences one adder operation at a time: accept command, pulse add_start, wait for add_done
//          (or time out), present the result until taken. Optional macro SUM_CHECK_EN adds a result check.
// Ports  : wb_clk_i / wb_rst_i (sync active-high); bus = instrumented_adder_driver_if.master.
// Timing : handshake at edge N -> add_* valid after N, add_start high for the single cycle after edge N+1;
//          all outputs are registered; rsp_* held while rsp_ready is low; cmd_ready only in IDLE with active.
module instrumented_adder_driver #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                          wb_clk_i,
  input  logic                          wb_rst_i,
  instrumented_adder_driver_if.master   bus
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] SETUP = 3'd1;
  localparam logic [2:0] START = 3'd2;
  localparam logic [2:0] WAIT  = 3'd3;
  localparam logic [2:0] RESP  = 3'd4;

  // Last counter value of the WAIT window; the counter starts at 0 on the first WAIT cycle.
  localparam logic [15:0] LAST_CNT = 16'(TIMEOUT_CYCLES - 1);

  logic [2:0]  state;
  logic [15:0] wait_cnt;
  logic        handshake;
  logic [1:0]  done_status;

  // active is also checked here so a command offered in the cycle active drops is not taken,
  // even though the registered cmd_ready only follows active one cycle later.
  assign handshake = (state == IDLE) && bus.active && bus.cmd_valid && bus.cmd_ready;

`ifdef SUM_CHECK_EN
  // Compare against the operands actually presented to the adder, wrapping at 32 bits.
  logic [31:0] exp_sum;
  assign exp_sum     = bus.add_a + bus.add_b;
  assign done_status = (bus.add_sum == exp_sum) ? 2'b00 : 2'b10;
`else
  assign done_status = 2'b00;
`endif

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state            <= IDLE;
      wait_cnt         <= 16'd0;
      bus.cmd_ready    <= 1'b0;
      bus.add_a        <= 32'd0;
      bus.add_b        <= 32'd0;
      bus.add_ring_sel <= 32'd0;
      bus.add_ext_sel  <= 32'd0;
      bus.add_start    <= 1'b0;
      bus.rsp_valid    <= 1'b0;
      bus.rsp_sum      <= 32'd0;
      bus.rsp_time     <= 32'd0;
      bus.rsp_status   <= 2'b00;
    end else begin
      // Single-cycle pulse / IDLE-only strobe by default.
      bus.add_start <= 1'b0;
      bus.cmd_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (handshake) begin
            bus.add_a        <= bus.cmd_a;
            bus.add_b        <= bus.cmd_b;
            bus.add_ring_sel <= bus.cmd_ring_sel;
            bus.add_ext_sel  <= bus.cmd_ext_sel;
            state            <= SETUP;
          end else begin
            bus.cmd_ready <= bus.active;
          end
        end
        SETUP: begin
          if (!bus.active) begin
            state <= IDLE;
          end else begin
            bus.add_start <= 1'b1;
            state         <= START;
          end
        end
        START: begin
          if (!bus.active) begin
            state <= IDLE;
          end else begin
            wait_cnt <= 16'd0;
            state    <= WAIT;
          end
        end
        WAIT: begin
          // Abort beats completion; completion beats timeout.
          if (!bus.active) begin
            state <= IDLE;
          end else if (bus.add_done) begin
            bus.rsp_sum    <= bus.add_sum;
            bus.rsp_time   <= bus.add_time;
            bus.rsp_status <= done_status;
            bus.rsp_valid  <= 1'b1;
            state          <= RESP;
          end else if (wait_cnt == LAST_CNT) begin
            bus.rsp_sum    <= 32'd0;
            bus.rsp_time   <= 32'hFFFF_FFFF;
            bus.rsp_status <= 2'b01;
            bus.rsp_valid  <= 1'b1;
            state          <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instrumented_adder_driver.sv
module tb_instrumented_adder_driver;
  localparam int T = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  instrumented_adder_driver_if bus ();

  instrumented_adder_driver #(.TIMEOUT_CYCLES(T)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .bus      (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Expected visible outputs for the current cycle, maintained by the transaction-level driver.
  logic        chk_en = 1'b0;
  logic        e_cmd_ready, e_rsp_valid, e_add_start;
  logic [31:0] e_add_a, e_add_b, e_ring, e_ext, e_rsp_sum, e_rsp_time;
  logic [1:0]  e_rsp_status;

  // Observed-event bookkeeping used by the literal checks.
  int          n_start = 0;
  int          n_rsp   = 0;
  logic [31:0] last_sum, last_time;
  logic [1:0]  last_status;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] model_status(input logic [31:0] a, input logic [31:0] b,
                                              input logic [31:0] s);
`ifdef SUM_CHECK_EN
    return (s == a + b) ? 2'b00 : 2'b10;
`else
    return 2'b00;
`endif
  endfunction

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cmd_ready", {31'd0, bus.cmd_ready}, {31'd0, e_cmd_ready});
      chk("rsp_valid", {31'd0, bus.rsp_valid}, {31'd0, e_rsp_valid});
      chk("add_start", {31'd0, bus.add_start}, {31'd0, e_add_start});
      chk("add_a", bus.add_a, e_add_a);
      chk("add_b", bus.add_b, e_add_b);
      chk("add_ring_sel", bus.add_ring_sel, e_ring);
      chk("add_ext_sel", bus.add_ext_sel, e_ext);
      if (e_rsp_valid) begin
        chk("rsp_sum", bus.rsp_sum, e_rsp_sum);
        chk("rsp_time", bus.rsp_time, e_rsp_time);
        chk("rsp_status", {30'd0, bus.rsp_status}, {30'd0, e_rsp_status});
      end
    end
    if (bus.add_start === 1'b1) n_start++;
    if (bus.rsp_valid === 1'b1 && bus.rsp_ready === 1'b1) begin
      n_rsp++;
      last_sum    = bus.rsp_sum;
      last_time   = bus.rsp_time;
      last_status = bus.rsp_status;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // IDLE cycles; active is randomised except on the last cycle, and a command
  // offered while active is low must not be accepted.
  task automatic idle(input int n);
    logic act;
    for (int i = 0; i < n; i++) begin
      act = (i == n - 1) ? 1'b1 : ($urandom_range(0, 3) != 0);
      bus.active    = act;
      bus.cmd_valid = !act;
      bus.cmd_a     = $urandom;
      bus.add_done  = 1'($urandom_range(0, 1));
      bus.add_sum   = $urandom;
      tick();
      e_cmd_ready = act;
    end
    bus.cmd_valid = 1'b0;
  endtask

  // One command from IDLE (cmd_ready high) back to IDLE.
  // done_k: WAIT cycle index carrying add_done (-1 = never); abort_ph: 0 none, 1 SETUP, 2 START, 3 WAIT cycle abort_k;
  // rst_k: WAIT cycle index in which reset is asserted (-1 = none).
  task automatic xact(input logic [31:0] a, input logic [31:0] b, input logic [31:0] rs,
                      input logic [31:0] es, input int done_k, input logic [31:0] sum,
                      input logic [31:0] tim, input int ready_dly, input int abort_ph,
                      input int abort_k, input int rst_k);
    bus.active       = 1'b1;
    bus.cmd_valid    = 1'b1;
    bus.cmd_a        = a;
    bus.cmd_b        = b;
    bus.cmd_ring_sel = rs;
    bus.cmd_ext_sel  = es;
    bus.add_done     = 1'($urandom_range(0, 1));
    tick();
    e_cmd_ready = 1'b0;
    e_add_a = a; e_add_b = b; e_ring = rs; e_ext = es;
    bus.cmd_valid = 1'($urandom_range(0, 1));
    bus.cmd_a     = $urandom;
    bus.cmd_b     = $urandom;
    // SETUP
    bus.add_done = 1'($urandom_range(0, 1));
    bus.active   = (abort_ph != 1);
    tick();
    if (abort_ph == 1) begin
      bus.active = 1'b1; bus.cmd_valid = 1'b0;
      return;
    end
    e_add_start = 1'b1;
    // START
    bus.add_done = 1'($urandom_range(0, 1));
    bus.active   = (abort_ph != 2);
    tick();
    e_add_start = 1'b0;
    bus.cmd_valid = 1'b0;
    if (abort_ph == 2) begin
      bus.active = 1'b1;
      return;
    end
    // WAIT: done at done_k, otherwise timeout after T cycles
    for (int k = 0; k < T; k++) begin
      bus.add_done = (k == done_k);
      bus.add_sum  = (k == done_k) ? sum : $urandom;
      bus.add_time = (k == done_k) ? tim : $urandom;
      bus.active   = !(abort_ph == 3 && k == abort_k);
      rst          = (k == rst_k);
      tick();
      if (k == rst_k) begin
        rst = 1'b0;
        e_add_a = '0; e_add_b = '0; e_ring = '0; e_ext = '0;
        e_rsp_valid = 1'b0; e_cmd_ready = 1'b0;
        chk("rst_wait.add_a", bus.add_a, 32'd0);
        chk("rst_wait.rsp_sum", bus.rsp_sum, 32'd0);
        chk("rst_wait.rsp_status", {30'd0, bus.rsp_status}, 32'd0);
        bus.active = 1'b1;
        return;
      end
      if (abort_ph == 3 && k == abort_k) begin
        bus.active = 1'b1;
        return;
      end
      if (k == done_k) begin
        e_rsp_valid = 1'b1; e_rsp_sum = sum; e_rsp_time = tim;
        e_rsp_status = model_status(a, b, sum);
        break;
      end
      if (k == T - 1) begin
        e_rsp_valid = 1'b1; e_rsp_sum = 32'd0; e_rsp_time = 32'hFFFF_FFFF;
        e_rsp_status = 2'b01;
      end
    end
    // RESP: active and add_done are don't-care here
    for (int j = 0; j < ready_dly; j++) begin
      bus.rsp_ready = 1'b0;
      bus.active    = 1'($urandom_range(0, 1));
      bus.add_done  = 1'($urandom_range(0, 1));
      tick();
    end
    bus.rsp_ready = 1'b1;
    bus.active    = 1'($urandom_range(0, 1));
    tick();
    e_rsp_valid   = 1'b0;
    bus.rsp_ready = 1'b0;
    bus.active    = 1'b1;
    bus.add_done  = 1'b0;
  endtask

  initial begin
    int s0, r0, dk, ph, rk;
    logic [31:0] a, b, s;
    rst = 1'b1;
    bus.active = 1'b1; bus.cmd_valid = 1'b0;
    bus.cmd_a = '0; bus.cmd_b = '0; bus.cmd_ring_sel = '0; bus.cmd_ext_sel = '0;
    bus.add_done = 1'b0; bus.add_sum = '0; bus.add_time = '0; bus.rsp_ready = 1'b0;
    tick();
    tick();
    e_cmd_ready = 1'b0; e_rsp_valid = 1'b0; e_add_start = 1'b0;
    e_add_a = '0; e_add_b = '0; e_ring = '0; e_ext = '0;
    e_rsp_sum = '0; e_rsp_time = '0; e_rsp_status = '0;
    chk_en = 1'b1;
    chk("reset.cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
    chk("reset.rsp_time", bus.rsp_time, 32'd0);
    rst = 1'b0;
    idle(3);

    // Normal run 5 + 7, done three cycles after add_start
    s0 = n_start; r0 = n_rsp;
    xact(32'd5, 32'd7, 32'hA5A5_0000, 32'h0000_5A5A, 2, 32'd12, 32'h40, 0, 0, 0, -1);
    chk("normal.sum", last_sum, 32'd12);
    chk("normal.time", last_time, 32'h40);
    chk("normal.status", {30'd0, last_status}, 32'd0);
    chk("normal.start_pulses", n_start - s0, 32'd1);
    chk("normal.responses", n_rsp - r0, 32'd1);
    idle(2);

    // Timeout
    xact(32'd1, 32'd2, 32'd0, 32'd0, -1, 32'd0, 32'd0, 0, 0, 0, -1);
    chk("timeout.sum", last_sum, 32'd0);
    chk("timeout.time", last_time, 32'hFFFF_FFFF);
    chk("timeout.status", {30'd0, last_status}, 32'd1);
    idle(1);

    // Done on the final WAIT cycle wins over timeout
    xact(32'h1000, 32'h234, 32'd3, 32'd4, T - 1, 32'h1234, 32'h77, 0, 0, 0, -1);
    chk("edge.sum", last_sum, 32'h1234);
    chk("edge.status", {30'd0, last_status}, 32'd0);
    idle(1);

    // Backpressure for 5 cycles
    r0 = n_rsp;
    xact(32'd9, 32'd9, 32'd0, 32'd0, 0, 32'd18, 32'h5, 5, 0, 0, -1);
    chk("bp.responses", n_rsp - r0, 32'd1);
    idle(1);

    // Abort in WAIT: no response
    r0 = n_rsp;
    xact(32'd3, 32'd4, 32'd0, 32'd0, 5, 32'd7, 32'd1, 0, 3, 3, -1);
    chk("abort.responses", n_rsp - r0, 32'd0);
    idle(2);

    // Reset mid-WAIT: outputs cleared, cmd_ready returns once reset is gone
    r0 = n_rsp;
    xact(32'hDEAD, 32'hBEEF, 32'hF0F0, 32'h0F0F, 5, 32'd0, 32'd0, 0, 0, 0, 2);
    chk("rst_wait.cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
    idle(1);
    chk("rst_wait.cmd_ready_after", {31'd0, bus.cmd_ready}, 32'd1);
    chk("rst_wait.responses", n_rsp - r0, 32'd0);

    // Wrapping sum and deliberate mismatch
    xact(32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 1, 32'd0, 32'd9, 0, 0, 0, -1);
    chk("wrap.status", {30'd0, last_status}, 32'd0);
    idle(1);
    xact(32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 1, 32'd1, 32'd9, 0, 0, 0, -1);
`ifdef SUM_CHECK_EN
    chk("mismatch.status", {30'd0, last_status}, 32'd2);
`else
    chk("mismatch.status", {30'd0, last_status}, 32'd0);
`endif
    chk("mismatch.sum", last_sum, 32'd1);
    idle(1);

    // Randomised commands
    for (int i = 0; i < 60; i++) begin
      a  = $urandom;
      b  = $urandom;
      s  = ($urandom_range(0, 2) != 0) ? a + b : $urandom;
      dk = $urandom_range(0, T + 1);
      if (dk == T + 1) dk = -1;
      ph = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 3) : 0;
      rk = ($urandom_range(0, 11) == 0) ? $urandom_range(0, T - 1) : -1;
      xact(a, b, $urandom, $urandom, dk, s, $urandom, $urandom_range(0, 3), ph,
           $urandom_range(0, T - 1), rk);
      idle($urandom_range(1, 3));
    end

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
